// File: rtl/window_ctrl_if.sv
// Request/bus bundle between a window requester, the memory port and window_ctrl.
// The master side issues save/restore/CSR writes and acks memory; the slave is the controller.
interface window_ctrl_if;
    logic       save;
    logic       restore;
    logic       wr_cwp;
    logic [1:0] cwp_in;
    logic       wr_wim;
    logic [3:0] wim_in;
    logic       mem_ack;
    logic [1:0] cwp;
    logic [3:0] wim;
    logic       busy;
    logic       trap;
    logic [1:0] trap_type;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] mem_win;
    logic [3:0] mem_idx;
    logic       done;

    modport master (
        output save, restore, wr_cwp, cwp_in, wr_wim, wim_in, mem_ack,
        input  cwp, wim, busy, trap, trap_type, mem_req, mem_we, mem_win, mem_idx, done
    );

    modport slave (
        input  save, restore, wr_cwp, cwp_in, wr_wim, wim_in, mem_ack,
        output cwp, wim, busy, trap, trap_type, mem_req, mem_we, mem_win, mem_idx, done
    );
endinterface

// File: rtl/window_ctrl.sv
// Register-window controller: tracks CWP/WIM, traps on overflow/underflow and
// sequences the 16-register spill or fill of the trapped window before moving CWP.
module window_ctrl (
    input  logic          clk,
    input  logic          reset,
    window_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_cwp;
    logic [3:0] r_wim;
    logic       r_trap;
    logic [1:0] r_trap_type;
    logic       r_mem_we;
    logic [1:0] r_mem_win;
    logic [3:0] r_mem_idx;

    state_t     w_state_next;
    logic [1:0] w_cwp_next;
    logic [3:0] w_wim_next;
    logic       w_trap_next;
    logic [1:0] w_trap_type_next;
    logic       w_mem_we_next;
    logic [1:0] w_mem_win_next;
    logic [3:0] w_mem_idx_next;
    logic [1:0] w_save_tgt;
    logic [1:0] w_rest_tgt;

    assign w_save_tgt = r_cwp - 2'd1;
    assign w_rest_tgt = r_cwp + 2'd1;

    always_comb begin
        w_state_next     = r_state;
        w_cwp_next       = r_cwp;
        w_wim_next       = r_wim;
        w_trap_next      = 1'b0;
        w_trap_type_next = r_trap_type;
        w_mem_we_next    = r_mem_we;
        w_mem_win_next   = r_mem_win;
        w_mem_idx_next   = r_mem_idx;
        case (r_state)
            ST_IDLE: begin
                if (bus.wr_wim)
                    w_wim_next = bus.wim_in;
                // wr_cwp wins over save, which wins over restore; losers are dropped.
                if (bus.wr_cwp) begin
                    w_cwp_next = bus.cwp_in;
                end else if (bus.save) begin
                    if (r_wim[w_save_tgt]) begin
                        w_trap_next      = 1'b1;
                        w_trap_type_next = 2'b01;
                        w_mem_we_next    = 1'b1;
                        w_mem_win_next   = w_save_tgt;
                        w_mem_idx_next   = 4'd0;
                        w_state_next     = ST_XFER;
                    end else begin
                        w_cwp_next = w_save_tgt;
                    end
                end else if (bus.restore) begin
                    if (r_wim[w_rest_tgt]) begin
                        w_trap_next      = 1'b1;
                        w_trap_type_next = 2'b10;
                        w_mem_we_next    = 1'b0;
                        w_mem_win_next   = w_rest_tgt;
                        w_mem_idx_next   = 4'd0;
                        w_state_next     = ST_XFER;
                    end else begin
                        w_cwp_next = w_rest_tgt;
                    end
                end
            end
            ST_XFER: begin
                if (bus.mem_ack) begin
                    if (r_mem_idx == 4'd15)
                        w_state_next = ST_DONE;
                    else
                        w_mem_idx_next = r_mem_idx + 4'd1;
                end
            end
            ST_DONE: begin
                // The invalid mark follows the window just freed/filled.
                w_cwp_next   = r_mem_win;
                w_wim_next   = r_mem_we ? {r_wim[0], r_wim[3:1]} : {r_wim[2:0], r_wim[3]};
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cwp       <= 2'b00;
            r_wim       <= 4'b0010;
            r_trap      <= 1'b0;
            r_trap_type <= 2'b00;
            r_mem_we    <= 1'b0;
            r_mem_win   <= 2'b00;
            r_mem_idx   <= 4'd0;
        end else begin
            r_state     <= w_state_next;
            r_cwp       <= w_cwp_next;
            r_wim       <= w_wim_next;
            r_trap      <= w_trap_next;
            r_trap_type <= w_trap_type_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_win   <= w_mem_win_next;
            r_mem_idx   <= w_mem_idx_next;
        end
    end

    assign bus.cwp       = r_cwp;
    assign bus.wim       = r_wim;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.trap      = r_trap;
    assign bus.trap_type = r_trap_type;
    assign bus.mem_req   = (r_state == ST_XFER);
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_win   = r_mem_win;
    assign bus.mem_idx   = r_mem_idx;
    assign bus.done      = (r_state == ST_DONE);
endmodule

// File: tb/tb_window_ctrl.sv
// Directed bench for window_ctrl: non-trapping moves, spill, fill, priority,
// reset during transfer and request blocking while busy.
module tb_window_ctrl;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    window_ctrl_if bus();

    window_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.save    = 1'b0;
        bus.restore = 1'b0;
        bus.wr_cwp  = 1'b0;
        bus.cwp_in  = 2'b00;
        bus.wr_wim  = 1'b0;
        bus.wim_in  = 4'b0000;
        bus.mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({bus.cwp, bus.wim, bus.busy, bus.trap, bus.trap_type, bus.mem_req, bus.mem_we,
             bus.mem_win, bus.mem_idx, bus.done} !== {2'b00, 4'b0010, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 4'd0, 1'b0}) begin
            $display("FAIL reset_state: cwp=%b wim=%b busy=%b trap=%b tt=%b req=%b we=%b win=%b idx=%0d done=%b",
                     bus.cwp, bus.wim, bus.busy, bus.trap, bus.trap_type, bus.mem_req, bus.mem_we,
                     bus.mem_win, bus.mem_idx, bus.done);
            n_err++;
        end
        $display("reset: cwp=%b wim=%b", bus.cwp, bus.wim);
    endtask

    task automatic test_save_nontrap();
        logic [1:0] exp_cwp [2];
        exp_cwp[0] = 2'd3;
        exp_cwp[1] = 2'd2;
        for (int i = 0; i < 2; i++) begin
            bus.save = 1'b1;
            tick();
            bus.save = 1'b0;
            n_vec++;
            if (bus.cwp !== exp_cwp[i] || bus.trap !== 1'b0 || bus.busy !== 1'b0 || bus.wim !== 4'b0010) begin
                $display("FAIL save_nontrap%0d: cwp=%b trap=%b busy=%b wim=%b, need cwp=%b trap=0 busy=0 wim=0010",
                         i, bus.cwp, bus.trap, bus.busy, bus.wim, exp_cwp[i]);
                n_err++;
            end
            $display("save: cwp=%b trap=%b", bus.cwp, bus.trap);
        end
    endtask

    // Entered with cwp=2, wim=0010.
    task automatic test_spill();
        bus.save    = 1'b1;
        bus.mem_ack = 1'b1;
        tick();
        bus.save = 1'b0;
        n_vec++;
        if (bus.trap !== 1'b1 || bus.trap_type !== 2'b01 || bus.mem_win !== 2'd1 || bus.mem_we !== 1'b1 ||
            bus.mem_req !== 1'b1 || bus.busy !== 1'b1) begin
            $display("FAIL spill_trap: trap=%b tt=%b win=%b we=%b req=%b busy=%b, need 1 01 01 1 1 1",
                     bus.trap, bus.trap_type, bus.mem_win, bus.mem_we, bus.mem_req, bus.busy);
            n_err++;
        end
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (bus.mem_idx !== 4'(i) || bus.mem_req !== 1'b1 || bus.mem_win !== 2'd1 ||
                (i > 0 && bus.trap !== 1'b0)) begin
                $display("FAIL spill_idx%0d: idx=%0d req=%b win=%b trap=%b", i, bus.mem_idx, bus.mem_req,
                         bus.mem_win, bus.trap);
                n_err++;
            end
            tick();
        end
        n_vec++;
        if (bus.done !== 1'b1 || bus.mem_req !== 1'b0 || bus.busy !== 1'b1 || bus.cwp !== 2'd2) begin
            $display("FAIL spill_done: done=%b req=%b busy=%b cwp=%b, need 1 0 1 10",
                     bus.done, bus.mem_req, bus.busy, bus.cwp);
            n_err++;
        end
        tick();
        bus.mem_ack = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b0 || bus.cwp !== 2'd1 || bus.wim !== 4'b0001 || bus.done !== 1'b0 ||
            bus.trap_type !== 2'b01) begin
            $display("FAIL spill_end: busy=%b cwp=%b wim=%b done=%b tt=%b, need 0 01 0001 0 01",
                     bus.busy, bus.cwp, bus.wim, bus.done, bus.trap_type);
            n_err++;
        end
        $display("spill: cwp=%b wim=%b", bus.cwp, bus.wim);
    endtask

    task automatic test_fill();
        int exp_idx;
        int c;
        logic ack;
        do_reset();
        bus.restore = 1'b1;
        tick();
        bus.restore = 1'b0;
        n_vec++;
        if (bus.trap !== 1'b1 || bus.trap_type !== 2'b10 || bus.mem_win !== 2'd1 || bus.mem_we !== 1'b0 ||
            bus.mem_idx !== 4'd0) begin
            $display("FAIL fill_trap: trap=%b tt=%b win=%b we=%b idx=%0d, need 1 10 01 0 0",
                     bus.trap, bus.trap_type, bus.mem_win, bus.mem_we, bus.mem_idx);
            n_err++;
        end
        exp_idx = 0;
        c = 0;
        while (exp_idx < 16 && c < 100) begin
            ack = (c % 3 == 2);
            bus.mem_ack = ack;
            tick();
            c++;
            if (ack) exp_idx++;
            if (exp_idx < 16) begin
                n_vec++;
                if (bus.mem_idx !== 4'(exp_idx) || bus.mem_req !== 1'b1) begin
                    $display("FAIL fill_idx_c%0d: idx=%0d req=%b, need idx=%0d req=1", c, bus.mem_idx,
                             bus.mem_req, exp_idx);
                    n_err++;
                end
            end
        end
        bus.mem_ack = 1'b0;
        n_vec++;
        if (exp_idx != 16 || bus.done !== 1'b1 || bus.mem_req !== 1'b0) begin
            $display("FAIL fill_done: acks=%0d done=%b req=%b, need 16 1 0", exp_idx, bus.done, bus.mem_req);
            n_err++;
        end
        tick();
        n_vec++;
        if (bus.cwp !== 2'd1 || bus.wim !== 4'b0100 || bus.busy !== 1'b0 || bus.trap_type !== 2'b10) begin
            $display("FAIL fill_end: cwp=%b wim=%b busy=%b tt=%b, need 01 0100 0 10",
                     bus.cwp, bus.wim, bus.busy, bus.trap_type);
            n_err++;
        end
        $display("fill: cwp=%b wim=%b cycles=%0d", bus.cwp, bus.wim, c);
    endtask

    task automatic test_priority();
        do_reset();
        bus.wr_cwp  = 1'b1;
        bus.cwp_in  = 2'd3;
        bus.save    = 1'b1;
        bus.restore = 1'b1;
        tick();
        idle_inputs();
        n_vec++;
        if (bus.cwp !== 2'd3 || bus.trap !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL priority: cwp=%b trap=%b busy=%b, need 11 0 0", bus.cwp, bus.trap, bus.busy);
            n_err++;
        end
        tick();
        n_vec++;
        if (bus.cwp !== 2'd3) begin
            $display("FAIL priority_hold: cwp=%b, need 11", bus.cwp);
            n_err++;
        end
        $display("priority: cwp=%b", bus.cwp);
    endtask

    task automatic test_reset_mid_xfer();
        do_reset();
        bus.restore = 1'b1;
        tick();
        bus.restore = 1'b0;
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        n_vec++;
        if (bus.mem_idx !== 4'd7 || bus.mem_req !== 1'b1) begin
            $display("FAIL midxfer_idx: idx=%0d req=%b, need 7 1", bus.mem_idx, bus.mem_req);
            n_err++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.mem_ack = 1'b0;
        n_vec++;
        if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.cwp !== 2'd0 || bus.wim !== 4'b0010 ||
            bus.mem_idx !== 4'd0 || bus.trap_type !== 2'b00) begin
            $display("FAIL midxfer_reset: req=%b busy=%b cwp=%b wim=%b idx=%0d tt=%b",
                     bus.mem_req, bus.busy, bus.cwp, bus.wim, bus.mem_idx, bus.trap_type);
            n_err++;
        end
        bus.save = 1'b1;
        tick();
        bus.save = 1'b0;
        n_vec++;
        if (bus.cwp !== 2'd3 || bus.trap !== 1'b0) begin
            $display("FAIL midxfer_save: cwp=%b trap=%b, need 11 0", bus.cwp, bus.trap);
            n_err++;
        end
        $display("reset_mid_xfer: cwp=%b wim=%b", bus.cwp, bus.wim);
    endtask

    task automatic test_busy_ignore();
        do_reset();
        bus.wr_wim = 1'b1;
        bus.wim_in = 4'b1111;
        tick();
        bus.wr_wim = 1'b0;
        n_vec++;
        if (bus.wim !== 4'b1111) begin
            $display("FAIL wim_write: wim=%b, need 1111", bus.wim);
            n_err++;
        end
        bus.mem_ack = 1'b1;
        tick();
        n_vec++;
        if (bus.mem_idx !== 4'd0 || bus.busy !== 1'b0) begin
            $display("FAIL ack_idle: idx=%0d busy=%b, need 0 0", bus.mem_idx, bus.busy);
            n_err++;
        end
        bus.save = 1'b1;
        tick();
        // Requests held during the whole transfer must have no effect.
        bus.wr_cwp = 1'b1;
        bus.cwp_in = 2'd2;
        bus.wr_wim = 1'b1;
        bus.wim_in = 4'b0000;
        n_vec++;
        if (bus.trap !== 1'b1 || bus.trap_type !== 2'b01 || bus.mem_win !== 2'd3) begin
            $display("FAIL busy_trap: trap=%b tt=%b win=%b, need 1 01 11", bus.trap, bus.trap_type, bus.mem_win);
            n_err++;
        end
        for (int i = 0; i < 16; i++) tick();
        n_vec++;
        if (bus.done !== 1'b1 || bus.cwp !== 2'd0 || bus.wim !== 4'b1111) begin
            $display("FAIL busy_hold: done=%b cwp=%b wim=%b, need 1 00 1111", bus.done, bus.cwp, bus.wim);
            n_err++;
        end
        tick();
        idle_inputs();
        n_vec++;
        if (bus.cwp !== 2'd3 || bus.wim !== 4'b1111 || bus.busy !== 1'b0) begin
            $display("FAIL busy_end: cwp=%b wim=%b busy=%b, need 11 1111 0", bus.cwp, bus.wim, bus.busy);
            n_err++;
        end
        bus.restore = 1'b1;
        tick();
        bus.restore = 1'b0;
        n_vec++;
        if (bus.trap !== 1'b1 || bus.trap_type !== 2'b10 || bus.mem_win !== 2'd0 || bus.mem_we !== 1'b0) begin
            $display("FAIL wim1111_restore: trap=%b tt=%b win=%b we=%b, need 1 10 00 0",
                     bus.trap, bus.trap_type, bus.mem_win, bus.mem_we);
            n_err++;
        end
        $display("busy_ignore: cwp=%b wim=%b", bus.cwp, bus.wim);
    endtask

    task automatic test_wim_zero();
        do_reset();
        bus.wr_wim = 1'b1;
        bus.wim_in = 4'b0000;
        tick();
        bus.wr_wim = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus.save = 1'b1;
            tick();
            bus.save = 1'b0;
            n_vec++;
            if (bus.cwp !== 2'(4 - i) || bus.trap !== 1'b0 || bus.busy !== 1'b0) begin
                $display("FAIL wim0_save%0d: cwp=%b trap=%b busy=%b, need cwp=%b", i, bus.cwp, bus.trap,
                         bus.busy, 2'(4 - i));
                n_err++;
            end
        end
        bus.restore = 1'b1;
        tick();
        bus.restore = 1'b0;
        n_vec++;
        if (bus.cwp !== 2'd0 || bus.trap !== 1'b0) begin
            $display("FAIL wim0_restore: cwp=%b trap=%b, need 00 0", bus.cwp, bus.trap);
            n_err++;
        end
        $display("wim_zero: cwp=%b", bus.cwp);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        idle_inputs();
        tick();
        test_reset();
        test_save_nontrap();
        test_spill();
        test_fill();
        test_priority();
        test_reset_mid_xfer();
        test_busy_ignore();
        test_wim_zero();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
